// File: rtl/dcache_pkg.sv
// Shared types and geometry helpers for the direct-mapped data cache.
package dcache_pkg;

    localparam int DCACHE_LINES = 16;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_WRITEBACK = 2'd1,
        S_REFILL    = 2'd2
    } dcache_state_e;

    localparam logic [1:0] ST_IDLE      = S_IDLE;
    localparam logic [1:0] ST_WRITEBACK = S_WRITEBACK;
    localparam logic [1:0] ST_REFILL    = S_REFILL;

    function automatic int idx_width(input int lines);
        return $clog2(lines);
    endfunction

    // Byte offset is two bits; everything above the index is tag.
    function automatic int tag_width(input int lines);
        return 32 - $clog2(lines) - 2;
    endfunction

endpackage

// File: rtl/dcache_line_store.sv
// Line storage: valid/dirty/tag/data arrays, one combinational read port, one edge write port.
module dcache_line_store
    import dcache_pkg::*;
#(
    parameter int LINES = DCACHE_LINES,
    parameter int IDX   = idx_width(DCACHE_LINES),
    parameter int TW    = tag_width(DCACHE_LINES)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [IDX-1:0] idx,
    output logic           rd_valid,
    output logic           rd_dirty,
    output logic [TW-1:0]  rd_tag,
    output logic [31:0]    rd_data,
    input  logic           valid_we,
    input  logic           valid_d,
    input  logic           dirty_we,
    input  logic           dirty_d,
    input  logic           tag_we,
    input  logic [TW-1:0]  tag_d,
    input  logic           data_we,
    input  logic [31:0]    data_d
);

    logic [LINES-1:0] valid;
    logic [LINES-1:0] dirty;
    logic [TW-1:0]    tags  [LINES];
    logic [31:0]      datas [LINES];

    assign rd_valid = valid[idx];
    assign rd_dirty = dirty[idx];
    assign rd_tag   = tags[idx];
    assign rd_data  = datas[idx];

    // Only the status bits are cleared; tag/data are don't-care while invalid.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= '0;
            dirty <= '0;
        end else begin
            if (valid_we) valid[idx] <= valid_d;
            if (dirty_we) dirty[idx] <= dirty_d;
        end
    end

    always_ff @(posedge clk) begin
        if (tag_we)  tags[idx]  <= tag_d;
        if (data_we) datas[idx] <= data_d;
    end

endmodule

// File: rtl/dcache_controller.sv
// Write-back, write-allocate direct-mapped data cache controller: hit logic and miss FSM.
module dcache_controller
    import dcache_pkg::*;
#(
    parameter int LINES = DCACHE_LINES
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] address_i,
    input  logic [31:0] write_data_i,
    input  logic        memread_i,
    input  logic        memwrite_i,
    output logic [31:0] read_data_o,
    output logic        stall_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_data_o,
    input  logic        mem_ack_i,
    input  logic [31:0] mem_data_i
);

    localparam int IDX = idx_width(LINES);
    localparam int TW  = tag_width(LINES);

    // Backing memory handshake: mem_req_o and its qualifiers stay constant until
    // the cycle mem_ack_i is sampled high; req drops the cycle after that ack.
    logic [1:0]     state;
    logic [1:0]     state_d;
    logic [31:2]    miss_addr;
    logic           access;
    logic           hit;
    logic [IDX-1:0] idx;
    logic [TW-1:0]  req_tag;

    logic           l_valid, l_dirty;
    logic [TW-1:0]  l_tag;
    logic [31:0]    l_data;
    logic           valid_we, valid_d, dirty_we, dirty_d, tag_we, data_we;
    logic [TW-1:0]  tag_d;
    logic [31:0]    data_d;

    logic unused_ok;
    assign unused_ok = ^address_i[1:0];

    assign access  = memread_i | memwrite_i;
    assign req_tag = address_i[31:IDX+2];
    assign idx     = (state == ST_IDLE) ? address_i[IDX+1:2] : miss_addr[IDX+1:2];
    assign hit     = l_valid && (l_tag == req_tag);

    dcache_line_store #(.LINES(LINES), .IDX(IDX), .TW(TW)) u_store (
        .clk      (clk_i),
        .rst      (rst_i),
        .idx      (idx),
        .rd_valid (l_valid),
        .rd_dirty (l_dirty),
        .rd_tag   (l_tag),
        .rd_data  (l_data),
        .valid_we (valid_we),
        .valid_d  (valid_d),
        .dirty_we (dirty_we),
        .dirty_d  (dirty_d),
        .tag_we   (tag_we),
        .tag_d    (tag_d),
        .data_we  (data_we),
        .data_d   (data_d)
    );

    always_comb begin
        state_d     = state;
        stall_o     = 1'b0;
        read_data_o = 32'd0;
        mem_req_o   = 1'b0;
        mem_we_o    = 1'b0;
        mem_addr_o  = 32'd0;
        mem_data_o  = 32'd0;
        valid_we    = 1'b0;
        valid_d     = 1'b0;
        dirty_we    = 1'b0;
        dirty_d     = 1'b0;
        tag_we      = 1'b0;
        tag_d       = miss_addr[31:IDX+2];
        data_we     = 1'b0;
        data_d      = write_data_i;
        case (state)
            ST_IDLE: begin
                if (access && hit) begin
                    if (memread_i) read_data_o = l_data;
                    if (memwrite_i) begin
                        data_we  = 1'b1;
                        dirty_we = 1'b1;
                        dirty_d  = 1'b1;
                    end
                end else if (access) begin
                    stall_o = 1'b1;
                    state_d = (l_valid && l_dirty) ? ST_WRITEBACK : ST_REFILL;
                end
            end
            ST_WRITEBACK: begin
                stall_o    = 1'b1;
                mem_req_o  = 1'b1;
                mem_we_o   = 1'b1;
                mem_addr_o = {l_tag, idx, 2'b00};
                mem_data_o = l_data;
                if (mem_ack_i) begin
                    dirty_we = 1'b1;
                    state_d  = ST_REFILL;
                end
            end
            ST_REFILL: begin
                stall_o    = 1'b1;
                mem_req_o  = 1'b1;
                mem_addr_o = {miss_addr, 2'b00};
                if (mem_ack_i) begin
                    valid_we = 1'b1;
                    valid_d  = 1'b1;
                    dirty_we = 1'b1;
                    tag_we   = 1'b1;
                    data_we  = 1'b1;
                    data_d   = mem_data_i;
                    state_d  = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state     <= ST_IDLE;
            miss_addr <= '0;
        end else begin
            state <= state_d;
            if (state == ST_IDLE && access && !hit) miss_addr <= address_i[31:2];
        end
    end

endmodule

// File: tb/tb_dcache_controller.sv
// Directed bench for dcache_controller: hits, clean/dirty misses, delayed ack, reset mid-refill.
module tb_dcache_controller;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] address;
    logic [31:0] write_data;
    logic        memread;
    logic        memwrite;
    logic [31:0] read_data;
    logic        stall;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_data_out;
    logic        mem_ack;
    logic [31:0] mem_data_in;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    dcache_controller #(.LINES(16)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .address_i    (address),
        .write_data_i (write_data),
        .memread_i    (memread),
        .memwrite_i   (memwrite),
        .read_data_o  (read_data),
        .stall_o      (stall),
        .mem_req_o    (mem_req),
        .mem_we_o     (mem_we),
        .mem_addr_o   (mem_addr),
        .mem_data_o   (mem_data_out),
        .mem_ack_i    (mem_ack),
        .mem_data_i   (mem_data_in)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled at the falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input logic rd, input logic wr, input logic [31:0] addr,
                         input logic [31:0] wdata);
        memread    = rd;
        memwrite   = wr;
        address    = addr;
        write_data = wdata;
        #1;
    endtask

    task automatic ack_with(input logic [31:0] d);
        mem_ack     = 1'b1;
        mem_data_in = d;
        tick();
        mem_ack     = 1'b0;
        mem_data_in = 32'd0;
        #1;
    endtask

    initial begin
        rst = 1'b1;
        mem_ack = 1'b0;
        mem_data_in = 32'd0;
        drive(1'b0, 1'b0, 32'd0, 32'd0);
        @(negedge clk);
        tick();
        tick();
        rst = 1'b0;
        #1;
        check("rst_stall", {31'd0, stall}, 32'd0);
        check("rst_req", {31'd0, mem_req}, 32'd0);
        check("rst_we", {31'd0, mem_we}, 32'd0);
        check("rst_addr", mem_addr, 32'd0);
        check("rst_wdata", mem_data_out, 32'd0);
        check("rst_rdata", read_data, 32'd0);

        // Clean read miss, ack on first refill cycle.
        drive(1'b1, 1'b0, 32'h40, 32'd0);
        check("m1_c0_stall", {31'd0, stall}, 32'd1);
        check("m1_c0_req", {31'd0, mem_req}, 32'd0);
        tick();
        check("m1_c1_stall", {31'd0, stall}, 32'd1);
        check("m1_c1_req", {31'd0, mem_req}, 32'd1);
        check("m1_c1_we", {31'd0, mem_we}, 32'd0);
        check("m1_c1_addr", mem_addr, 32'h40);
        ack_with(32'h11112222);
        check("m1_c2_stall", {31'd0, stall}, 32'd0);
        check("m1_c2_rdata", read_data, 32'h11112222);
        check("m1_c2_req", {31'd0, mem_req}, 32'd0);
        tick();
        check("m1_rep_stall", {31'd0, stall}, 32'd0);
        check("m1_rep_rdata", read_data, 32'h11112222);

        // Write hit; read-back next cycle.
        drive(1'b0, 1'b1, 32'h40, 32'hDEADBEEF);
        check("wh_stall", {31'd0, stall}, 32'd0);
        check("wh_rdata", read_data, 32'd0);
        tick();
        drive(1'b1, 1'b0, 32'h40, 32'd0);
        check("wh_rd_stall", {31'd0, stall}, 32'd0);
        check("wh_rd_data", read_data, 32'hDEADBEEF);

        // Dirty eviction: 0x80 maps to the same index as 0x40.
        drive(1'b1, 1'b0, 32'h80, 32'd0);
        check("ev_c0_stall", {31'd0, stall}, 32'd1);
        check("ev_c0_rdata", read_data, 32'd0);
        tick();
        for (int i = 0; i < 2; i++) begin
            check("ev_wb_req", {31'd0, mem_req}, 32'd1);
            check("ev_wb_we", {31'd0, mem_we}, 32'd1);
            check("ev_wb_addr", mem_addr, 32'h40);
            check("ev_wb_data", mem_data_out, 32'hDEADBEEF);
            check("ev_wb_stall", {31'd0, stall}, 32'd1);
            if (i == 0) tick();
        end
        ack_with(32'd0);
        check("ev_rf_req", {31'd0, mem_req}, 32'd1);
        check("ev_rf_we", {31'd0, mem_we}, 32'd0);
        check("ev_rf_addr", mem_addr, 32'h80);
        ack_with(32'h33334444);
        check("ev_done_stall", {31'd0, stall}, 32'd0);
        check("ev_done_rdata", read_data, 32'h33334444);

        // Write miss on clean line: refill, then write hit.
        drive(1'b0, 1'b1, 32'hC0, 32'h5);
        check("wm_c0_stall", {31'd0, stall}, 32'd1);
        tick();
        check("wm_rf_we", {31'd0, mem_we}, 32'd0);
        check("wm_rf_addr", mem_addr, 32'hC0);
        ack_with(32'h77777777);
        check("wm_hit_stall", {31'd0, stall}, 32'd0);
        tick();
        drive(1'b1, 1'b0, 32'hC0, 32'd0);
        check("wm_rd_data", read_data, 32'h5);
        drive(1'b1, 1'b0, 32'h40, 32'd0);
        check("wm_ev_stall", {31'd0, stall}, 32'd1);
        tick();
        check("wm_wb_we", {31'd0, mem_we}, 32'd1);
        check("wm_wb_addr", mem_addr, 32'hC0);
        check("wm_wb_data", mem_data_out, 32'h5);
        ack_with(32'd0);
        check("wm_rf2_addr", mem_addr, 32'h40);
        ack_with(32'hAAAA0000);
        check("wm_rf2_rdata", read_data, 32'hAAAA0000);

        // Refill ack delayed by 3 cycles: five stall cycles in total.
        drive(1'b1, 1'b0, 32'h104, 32'd0);
        for (int i = 0; i < 5; i++) begin
            check("dl_stall", {31'd0, stall}, 32'd1);
            if (i >= 1) begin
                check("dl_req", {31'd0, mem_req}, 32'd1);
                check("dl_addr", mem_addr, 32'h104);
                check("dl_we", {31'd0, mem_we}, 32'd0);
            end
            if (i == 4) ack_with(32'h12345678);
            else tick();
        end
        check("dl_done_stall", {31'd0, stall}, 32'd0);
        check("dl_done_rdata", read_data, 32'h12345678);

        // Stray ack in IDLE with no access.
        drive(1'b0, 1'b0, 32'h104, 32'd0);
        ack_with(32'hFFFFFFFF);
        check("stray_req", {31'd0, mem_req}, 32'd0);
        check("stray_stall", {31'd0, stall}, 32'd0);
        drive(1'b1, 1'b0, 32'h104, 32'd0);
        check("stray_hit_stall", {31'd0, stall}, 32'd0);
        check("stray_hit_rdata", read_data, 32'h12345678);

        // Reset asserted mid-refill.
        drive(1'b1, 1'b0, 32'h200, 32'd0);
        check("rr_c0_stall", {31'd0, stall}, 32'd1);
        tick();
        check("rr_rf_req", {31'd0, mem_req}, 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        drive(1'b0, 1'b0, 32'h200, 32'd0);
        check("rr_req_drop", {31'd0, mem_req}, 32'd0);
        ack_with(32'h55555555);
        check("rr_late_ack_req", {31'd0, mem_req}, 32'd0);
        check("rr_late_ack_stall", {31'd0, stall}, 32'd0);
        drive(1'b1, 1'b0, 32'h104, 32'd0);
        check("rr_inv_104", {31'd0, stall}, 32'd1);
        check("rr_inv_104_rdata", read_data, 32'd0);
        drive(1'b1, 1'b0, 32'h40, 32'd0);
        check("rr_inv_40", {31'd0, stall}, 32'd1);
        drive(1'b1, 1'b0, 32'h200, 32'd0);
        check("rr_miss_200", {31'd0, stall}, 32'd1);
        tick();
        check("rr_rf_again_addr", mem_addr, 32'h200);
        check("rr_rf_again_req", {31'd0, mem_req}, 32'd1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
